// File: rtl/risc_pipe_ctrl.sv
// Issue controller between decode and execute: RAW scoreboard, in-flight window, start/halt/drain FSM.
// Latency: fetch_en/issue/stall are combinational from registered state + current inputs; state/halted/inflight update at posedge.
// Backpressure: stall (and fetch_en low) holds fetch/decode on RAW hazard or full window; STALL re-evaluates one cycle later.
// Optional build macro RISC_PIPE_CTRL_STATS_EN adds a saturating 16-bit stall_cnt output.
module risc_pipe_ctrl #(
    parameter int NREG         = 8,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       halt_req,
    input  logic       dec_valid,
    input  logic [3:0] dec_opcode,
    input  logic [2:0] dec_dst,
    input  logic [2:0] dec_opnda,
    input  logic [2:0] dec_opndb,
    input  logic       wb_valid,
    input  logic [2:0] wb_dst,
    output logic       fetch_en,
    output logic       issue,
    output logic       stall,
    output logic       halted,
    output logic [2:0] state,
    output logic [2:0] inflight
`ifdef RISC_PIPE_CTRL_STATS_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STALL  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam logic [3:0] OP_HLT = 4'b1101;
    localparam logic [3:0] OP_LD  = 4'b1110;
    localparam logic [3:0] OP_ST  = 4'b1111;
    localparam logic [2:0] MAX_W  = 3'(MAX_INFLIGHT);

    state_t            cur;
    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_nxt;
    logic [NREG-1:0]   wb_mask;
    logic [NREG-1:0]   eff;
    logic [2:0]        inflight_q;

    logic is_alu;
    logic is_hlt;
    logic is_ld;
    logic is_st;
    logic rd_a;
    logic rd_b;
    logic writer;
    logic wb_hit;
    logic hazard;
    logic full;
    logic inc;
    logic dec;
    logic [2:0] infl_after_wb;

    assign state    = cur;
    assign inflight = inflight_q;

    // Opcode class decode: ALU reads both operands, st reads only its data operand, ld/ALU write dst.
    always_comb begin
        is_alu = (dec_opcode <= 4'b1100);
        is_hlt = (dec_opcode == OP_HLT);
        is_ld  = (dec_opcode == OP_LD);
        is_st  = (dec_opcode == OP_ST);
        rd_a   = is_alu | is_st;
        rd_b   = is_alu;
        writer = is_alu | is_ld;
    end

    // Same-cycle write-back bypass: a register completing now no longer blocks the decoder.
    always_comb begin
        wb_mask = '0;
        if (wb_valid) begin
            wb_mask[wb_dst] = 1'b1;
        end
        eff    = pend & ~wb_mask;
        wb_hit = wb_valid & pend[wb_dst];
    end

    // Hazard and window-full evaluation; the window is judged after this cycle's write-back retires.
    always_comb begin
        infl_after_wb = inflight_q;
        if (wb_hit && inflight_q != 3'd0) begin
            infl_after_wb = inflight_q - 3'd1;
        end
        hazard = dec_valid & ((rd_a & eff[dec_opnda]) | (rd_b & eff[dec_opndb]));
        full   = dec_valid & writer & (infl_after_wb == MAX_W);
    end

    // Pipeline handshake outputs; only RUN may issue, and a pending halt request blocks issue.
    always_comb begin
        issue    = 1'b0;
        stall    = 1'b0;
        fetch_en = 1'b0;
        case (cur)
            ST_RUN: begin
                stall    = dec_valid & (hazard | full);
                issue    = dec_valid & ~hazard & ~full & ~is_hlt & ~halt_req;
                fetch_en = ~stall;
            end
            ST_STALL: begin
                stall = 1'b1;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // Next scoreboard: a retiring write-back clears, a new writer sets; set is applied last so it wins.
    always_comb begin
        inc      = issue & writer;
        dec      = wb_hit & (inflight_q != 3'd0);
        pend_nxt = pend;
        if (wb_hit) begin
            pend_nxt[wb_dst] = 1'b0;
        end
        if (inc) begin
            pend_nxt[dec_dst] = 1'b1;
        end
    end

    // Scoreboard and in-flight counter registers; write-backs to non-pending registers are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= '0;
            inflight_q <= 3'd0;
        end else begin
            pend <= pend_nxt;
            case ({inc, dec})
                2'b10:   inflight_q <= inflight_q + 3'd1;
                2'b01:   inflight_q <= inflight_q - 3'd1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Control FSM: start/run/stall/drain/halt sequencing with registered halted flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur    <= ST_IDLE;
            halted <= 1'b0;
        end else begin
            case (cur)
                ST_IDLE: begin
                    if (start) begin
                        cur <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt_req || (dec_valid && is_hlt)) begin
                        cur <= ST_DRAIN;
                    end else if (stall) begin
                        cur <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (halt_req) begin
                        cur <= ST_DRAIN;
                    end else if (!hazard && !full) begin
                        cur <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (pend == '0 && inflight_q == 3'd0) begin
                        cur    <= ST_HALTED;
                        halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (start) begin
                        cur    <= ST_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    cur    <= ST_IDLE;
                    halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef RISC_PIPE_CTRL_STATS_EN
    logic start_ok;
    assign start_ok = start & ((cur == ST_IDLE) | (cur == ST_HALTED));

    // Saturating stall-cycle counter, restarted whenever a start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if (start_ok) begin
            stall_cnt <= 16'd0;
        end else if (stall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_risc_pipe_ctrl.sv
// Bench for risc_pipe_ctrl: directed scenarios plus randomized traffic against a rule-level reference model.
// Inputs change at negedge, combinational outputs sampled 2ns later, registered outputs sampled 1ns after posedge.
// Every wait is a bounded clock count; a global watchdog ends a runaway simulation.
module tb_risc_pipe_ctrl;

    localparam int MAXI = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_STALL = 2, M_DRAIN = 3, M_HALTED = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, halt_req = 1'b0, dec_valid = 1'b0, wb_valid = 1'b0;
    logic [3:0] dec_opcode = 4'd0;
    logic [2:0] dec_dst = 3'd0, dec_opnda = 3'd0, dec_opndb = 3'd0, wb_dst = 3'd0;
    logic       fetch_en, issue, stall, halted;
    logic [2:0] state, inflight;
`ifdef RISC_PIPE_CTRL_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_state;
    bit m_pend[8];
    int m_infl;
    int m_cnt;

    // combinational outputs seen in the most recent step
    int o_issue, o_stall, o_fetch;

    risc_pipe_ctrl #(.NREG(8), .MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .dec_valid(dec_valid), .dec_opcode(dec_opcode), .dec_dst(dec_dst),
        .dec_opnda(dec_opnda), .dec_opndb(dec_opndb),
        .wb_valid(wb_valid), .wb_dst(wb_dst),
        .fetch_en(fetch_en), .issue(issue), .stall(stall), .halted(halted),
        .state(state), .inflight(inflight)
`ifdef RISC_PIPE_CTRL_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        for (int r = 0; r < 8; r++) m_pend[r] = 0;
        m_infl = 0;
        m_cnt  = 0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        start = 0; halt_req = 0; dec_valid = 0; wb_valid = 0;
        #1;
        chk({tag, "_state"}, state, 0);
        chk({tag, "_inflight"}, inflight, 0);
        chk({tag, "_issue"}, issue, 0);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_fetch"}, fetch_en, 0);
        chk({tag, "_halted"}, halted, 0);
`ifdef RISC_PIPE_CTRL_STATS_EN
        chk({tag, "_stall_cnt"}, stall_cnt, 0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, compare against the model, advance the model across the edge.
    task automatic step(input bit s, input bit hr, input bit dv, input int op,
                        input int d, input int a, input int b, input bit wv, input int wd);
        bit wr, ra, rb, hit, hz, fl, e_iss, e_stl, e_fe, empty;
        int left;
        @(negedge clk);
        start = s; halt_req = hr; dec_valid = dv; dec_opcode = 4'(op);
        dec_dst = 3'(d); dec_opnda = 3'(a); dec_opndb = 3'(b);
        wb_valid = wv; wb_dst = 3'(wd);
        #2;
        wr  = (op <= 12) || (op == 14);
        ra  = (op <= 12) || (op == 15);
        rb  = (op <= 12);
        hit = wv && m_pend[wd];
        hz  = dv && ((ra && m_pend[a] && !(wv && wd == a)) ||
                     (rb && m_pend[b] && !(wv && wd == b)));
        left = m_infl - (hit ? 1 : 0);
        if (left < 0) left = 0;
        fl = dv && wr && (left == MAXI);
        if (m_state == M_RUN) begin
            e_stl = dv && (hz || fl);
            e_iss = dv && !hz && !fl && (op != 13) && !hr;
            e_fe  = !e_stl;
        end else begin
            e_stl = (m_state == M_STALL);
            e_iss = 0;
            e_fe  = 0;
        end
        o_issue = issue; o_stall = stall; o_fetch = fetch_en;
        chk("issue", issue, e_iss);
        chk("stall", stall, e_stl);
        chk("fetch_en", fetch_en, e_fe);
        chk("state", state, m_state);
        chk("inflight", inflight, m_infl);
        chk("halted", halted, m_state == M_HALTED);
`ifdef RISC_PIPE_CTRL_STATS_EN
        chk("stall_cnt", stall_cnt, m_cnt);
`endif
        @(posedge clk);
        empty = 1;
        for (int r = 0; r < 8; r++) if (m_pend[r]) empty = 0;
        if ((m_state == M_IDLE || m_state == M_HALTED) && s) m_cnt = 0;
        else if (e_stl && m_cnt < 65535) m_cnt++;
        case (m_state)
            M_IDLE:   if (s) m_state = M_RUN;
            M_RUN:    if (hr || (dv && op == 13)) m_state = M_DRAIN;
                      else if (e_stl) m_state = M_STALL;
            M_STALL:  if (hr) m_state = M_DRAIN;
                      else if (!hz && !fl) m_state = M_RUN;
            M_DRAIN:  if (empty && m_infl == 0) m_state = M_HALTED;
            M_HALTED: if (s) m_state = M_RUN;
            default:  m_state = M_IDLE;
        endcase
        if (e_iss && wr) m_infl++;
        if (hit && m_infl > 0 && !(e_iss && wr && m_infl == 0)) m_infl--;
        if (hit) m_pend[wd] = 0;
        if (e_iss && wr) m_pend[d] = 1;
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        #3;
        rst_n = 1'b1;

        // RAW stall, wb release, re-issue
        do_reset("t1_rst");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_run", state, M_RUN);
        step(0, 0, 1, 0, 1, 2, 3, 0, 0);
        chk("t1_issue_first", o_issue, 1);
        step(0, 0, 1, 1, 4, 1, 2, 0, 0);
        chk("t1_raw_stall", o_stall, 1);
        chk("t1_in_stall", state, M_STALL);
        step(0, 0, 1, 1, 4, 1, 2, 1, 1);
        chk("t1_back_run", state, M_RUN);
        step(0, 0, 1, 1, 4, 1, 2, 0, 0);
        chk("t1_reissue", o_issue, 1);

        // same-cycle write-back bypass on r4
        step(0, 0, 1, 3, 5, 4, 0, 1, 4);
        chk("t2_bypass_stall", o_stall, 0);
        chk("t2_bypass_issue", o_issue, 1);
        chk("t2_inflight", inflight, 1);

        // window full; a store is not a writer
        do_reset("t3_rst");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 14, 1, 0, 0, 0, 0);
        step(0, 0, 1, 14, 2, 0, 0, 0, 0);
        step(0, 0, 1, 14, 3, 0, 0, 0, 0);
        chk("t3_inflight3", inflight, 3);
        step(0, 0, 1, 15, 0, 5, 0, 0, 0);
        chk("t3_st_issues", o_issue, 1);
        step(0, 0, 1, 14, 4, 0, 0, 0, 0);
        chk("t3_full_stall", o_stall, 1);
        chk("t3_full_noissue", o_issue, 0);
        chk("t3_full_state", state, M_STALL);

        // set beats clear on the same register
        do_reset("t4_rst");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 14, 2, 0, 0, 0, 0);
        step(0, 0, 1, 2, 2, 6, 7, 1, 2);
        chk("t4_issue", o_issue, 1);
        chk("t4_inflight_same", inflight, 1);
        step(0, 0, 1, 0, 3, 2, 6, 0, 0);
        chk("t4_r2_still_pending", o_stall, 1);

        // HLT drains then halts, start resumes
        do_reset("t5_rst");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 14, 1, 0, 0, 0, 0);
        step(0, 0, 1, 14, 2, 0, 0, 0, 0);
        step(0, 0, 1, 13, 0, 0, 0, 0, 0);
        chk("t5_drain", state, M_DRAIN);
        idle();
        chk("t5_drain_nofetch", o_fetch, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 2);
        chk("t5_still_drain", state, M_DRAIN);
        idle();
        chk("t5_halted_state", state, M_HALTED);
        chk("t5_halted_flag", halted, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_restart", state, M_RUN);

        // async reset mid-operation; stale write-back ignored
        step(0, 0, 1, 14, 3, 0, 0, 0, 0);
        do_reset("t7_midrst");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 3);
        chk("t7_stale_wb", inflight, 0);

`ifdef RISC_PIPE_CTRL_STATS_EN
        do_reset("t6_rst");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 14, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 2, 1, 1, 0, 0);
        chk("t6_cnt5", stall_cnt, 5);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle();
        chk("t6_halted", state, M_HALTED);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_cnt_clr", stall_cnt, 0);
`endif

        // randomized traffic against the model
        do_reset("rnd_rst");
        for (int n = 0; n < 3000; n++) begin
            int op;
            if (n % 750 == 749) do_reset("rnd_midrst");
            op = $urandom_range(0, 15);
            if (op == 13 && $urandom_range(0, 3) != 0) op = 14;
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 3) != 0), op,
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 ($urandom_range(0, 2) == 0), $urandom_range(0, 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/risc_pipe_ctrl.md
Name: risc_pipe_ctrl

Overview:
Issue controller for the 4-stage RISC pipeline (fetch, decode, execute, write-back). Sits between the decode stage and execute.
- Holds a per-register pending-write scoreboard and counts in-flight writers.
- Stalls fetch/decode on RAW hazards or a full in-flight window.
- Runs the start / halt / drain sequence.

Parameters:
- NREG, 8, architectural registers; register fields are 3 bits wide.
- MAX_INFLIGHT, 3, maximum issued-but-not-written-back writers (1..7).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; leaves IDLE or HALTED
- halt_req  in  1  external halt request (level)
- dec_valid  in  1  decode outputs hold a valid instruction
- dec_opcode  in  4  decoded opcode
- dec_dst  in  3  destination register
- dec_opnda  in  3  operand a register
- dec_opndb  in  3  operand b register
- wb_valid  in  1  write-back completing this cycle
- wb_dst  in  3  register being written back
- fetch_en  out  1  advance PC/IR
- issue  out  1  execute accepts the decoded instruction this cycle
- stall  out  1  hazard or window-full stall
- halted  out  1  state is HALTED
- state  out  3  IDLE=0, RUN=1, STALL=2, DRAIN=3, HALTED=4
- inflight  out  3  current in-flight writer count

Behaviour:
- Opcode classes:
  - 0000-1100 ALU: reads opnda and opndb, writes dst.
  - 1101 HLT: no reads, no write.
  - 1110 ld: writes dst, no reads.
  - 1111 st: reads opnda (store data), no write.
- Reset: state=IDLE, scoreboard=0, inflight=0. fetch_en, issue, stall and halted are all 0.
- Effective pending: eff = pend & ~(wb_valid ? onehot(wb_dst) : 0). Write-back is visible to the decoder in the same cycle.
- hazard = dec_valid and (any read register with eff set).
- full = (inflight == MAX_INFLIGHT, counted after this cycle's wb decrement) and the instruction is a writer.
- fetch_en, issue and stall are combinational from the registered state, registered scoreboard and current inputs:
  - RUN: issue = dec_valid & ~hazard & ~full & opcode!=HLT; stall = dec_valid & (hazard|full); fetch_en = ~stall.
  - All other states: issue=0 and fetch_en=0. stall=1 in STALL, 0 elsewhere.
- Scoreboard at posedge:
  - Clear pend[wb_dst] on wb_valid.
  - Set pend[dec_dst] on issue of a writer.
  - Set wins over clear when both target the same register.
  - wb_valid on a non-pending register: no scoreboard change, and inflight does not decrement.
- inflight: +1 on writer issue, -1 on a valid wb clear. Simultaneous inc and dec leaves it unchanged. It never exceeds MAX_INFLIGHT and never underflows.
- State transitions:
  - IDLE: start -> RUN.
  - RUN:
    - halt_req, or dec_valid with opcode HLT -> DRAIN. halt_req has priority over issue, so nothing issues that cycle.
    - Otherwise, stall -> STALL.
  - STALL: once hazard and full are both clear -> RUN. The instruction issues in the first RUN cycle, one cycle of re-evaluation latency. halt_req -> DRAIN.
  - DRAIN: when the scoreboard is all-zero and inflight==0 -> HALTED.
  - HALTED: halted=1; start -> RUN. start in any other state is ignored.
- Async reset mid-operation clears everything immediately. The in-flight count is lost, and later wb_valid pulses are ignored by the non-pending rule.

Optional Feature:
- Macro: RISC_PIPE_CTRL_STATS_EN.
- When defined:
  - Extra output stall_cnt (16 bits): increments every cycle stall=1, saturates at 16'hFFFF.
  - Cleared to 0 on reset and on an accepted start.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset, then start; issue ALU r1<=r2+r3; next cycle issue ALU reading r1 with no wb -> stall=1, state=STALL. Pulse wb_valid wb_dst=1 -> RUN the next cycle, then issue=1.
2. Decode reads r4 while wb_valid wb_dst=4 in the same cycle -> no stall, issue=1.
3. Issue 3 ld ops to r1, r2, r3 with no wb -> inflight=3; a 4th writer stalls. A st reading r5 in that state issues (not a writer).
4. Issue ALU to r2 with wb_valid wb_dst=2 in the same cycle -> pend[2] stays 1, inflight unchanged.
5. Decode HLT with 2 in flight -> DRAIN, fetch_en=0. Two wb pulses -> HALTED, halted=1. Then start -> RUN.
6. With RISC_PIPE_CTRL_STATS_EN defined: 5 stall cycles -> stall_cnt=5; start from HALTED -> stall_cnt=0.
